// File: rtl/digit_scan_counter_pkg.sv
// Shared constants and helpers for the BCD digit-scan counter.
package digit_scan_counter_pkg;

    localparam int          DIGIT_W     = 4;
    localparam logic [3:0]  DIGIT_BLANK = 4'hF;
    localparam logic [3:0]  BCD_MAX     = 4'd9;

    typedef logic [DIGIT_W-1:0] bcd_t;

    // Non-decimal codes collapse to 0 so the count always stays valid BCD.
    function automatic bcd_t bcd_sat(input bcd_t nib);
        return (nib > BCD_MAX) ? bcd_t'(0) : nib;
    endfunction

endpackage

// File: rtl/digit_scan_counter_if.sv
// Control inputs and display/count outputs of the digit-scan counter.
interface digit_scan_counter_if
    import digit_scan_counter_pkg::*;
#(
    parameter int DIGITS = 4
);
    logic                      en;
    logic                      up;
    logic                      clr;
    logic                      load;
    logic [DIGIT_W*DIGITS-1:0] load_val;
    logic [DIGIT_W-1:0]        digit;
    logic [DIGITS-1:0]         sel;
    logic                      carry;
    logic [DIGIT_W*DIGITS-1:0] value;

    modport master (
        output en, up, clr, load, load_val,
        input  digit, sel, carry, value
    );

    modport slave (
        input  en, up, clr, load, load_val,
        output digit, sel, carry, value
    );
endinterface

// File: rtl/digit_scan_counter_bcd_decade.sv
// One BCD decade: clear, saturating load, and ripple increment/decrement.
module bcd_decade
    import digit_scan_counter_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         ld,
    input  logic         clr,
    input  bcd_t         ld_val,
    input  logic         ci,
    output logic         co,
    output bcd_t         q
);
    bcd_t q_q, q_d;

    // Carry/borrow out only when this decade actually wraps.
    assign co = ci && ((inc && q_q == BCD_MAX) || (dec && q_q == bcd_t'(0)));
    assign q  = q_q;

    always_comb begin
        // NOTE: default assignment first so no latch is inferred on idle paths.
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (ld) begin
            q_d = bcd_sat(ld_val);
        end else if (ci && inc) begin
            q_d = (q_q == BCD_MAX) ? bcd_t'(0) : q_q + bcd_t'(1);
        end else if (ci && dec) begin
            q_d = (q_q == bcd_t'(0)) ? BCD_MAX : q_q - bcd_t'(1);
        end
    end

    // NOTE: non-blocking assignment so every decade samples the same pre-edge state.
    always_ff @(posedge clk) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end
endmodule

// File: rtl/digit_scan_counter.sv
// Four-decade BCD up/down counter with registered digit-scan outputs
// feeding a downstream BCD-to-7-segment decoder.
module digit_scan_counter
    import digit_scan_counter_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000,
    parameter int BLANK_LZ = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    digit_scan_counter_if.slave  bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(DIGITS);

    logic [PW-1:0]             pcnt_q, pcnt_d;
    logic [SW-1:0]             scnt_q, scnt_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [DIGITS-1:0]         sel_q, sel_d;
    bcd_t                      digit_q, digit_d;
    logic                      carry_q;
    logic [DIGIT_W*DIGITS-1:0] value_w;
    logic [DIGITS:0]           chain;
    logic                      tick, count_step, scan_tc, upper_zero;

    assign tick       = bus.en && (pcnt_q == PW'(TICK_DIV - 1));
    // A tick that collides with clr or load is dropped entirely.
    assign count_step = tick && !bus.clr && !bus.load;
    assign scan_tc    = (scnt_q == SW'(SCAN_DIV - 1));
    assign chain[0]   = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_decade
        bcd_decade u_decade (
            .clk    (clk),
            .rst_n  (rst_n),
            .inc    (count_step && bus.up),
            .dec    (count_step && !bus.up),
            .ld     (bus.load),
            .clr    (bus.clr),
            .ld_val (bus.load_val[g*DIGIT_W +: DIGIT_W]),
            .ci     (chain[g]),
            .co     (chain[g+1]),
            .q      (value_w[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_comb begin
        pcnt_d = pcnt_q;
        if (bus.clr)     pcnt_d = '0;
        else if (tick)   pcnt_d = '0;
        else if (bus.en) pcnt_d = pcnt_q + PW'(1);

        scnt_d = scan_tc ? '0 : scnt_q + SW'(1);
        idx_d  = idx_q;
        if (scan_tc) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);

        sel_d = '0;
        sel_d[idx_q] = 1'b1;
    end

    // Blank when the current decade and everything above it are zero.
    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(idx_q) && value_w[i*DIGIT_W +: DIGIT_W] != bcd_t'(0))
                upper_zero = 1'b0;
        end
        digit_d = value_w[idx_q*DIGIT_W +: DIGIT_W];
        if (BLANK_LZ != 0 && idx_q != '0 && upper_zero) digit_d = DIGIT_BLANK;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt_q  <= '0;
            scnt_q  <= '0;
            idx_q   <= '0;
            sel_q   <= DIGITS'(1);
            digit_q <= '0;
            carry_q <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            scnt_q  <= scnt_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            digit_q <= digit_d;
            carry_q <= chain[DIGITS];
        end
    end

    assign bus.value = value_w;
    assign bus.sel   = sel_q;
    assign bus.digit = digit_q;
    assign bus.carry = carry_q;
endmodule

// File: tb/tb_digit_scan_counter.sv
// Scoreboard bench: the driver queues expected outputs tagged with the
// cycle they are due; a negedge monitor pops and compares them.
module tb_digit_scan_counter;
    import digit_scan_counter_pkg::*;

    localparam int DIGITS = 4;

    typedef enum {K_VALUE, K_CARRY, K_SEL, K_DIGIT, K_DIGIT_B} kind_e;
    typedef struct {
        int unsigned cyc;
        kind_e       kind;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned n = 0;
    int unsigned m = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    // Hand-computed scan tables: sel after the m-th post-reset edge, and
    // digit per scan index for each test value (lz = blanked, nb = not).
    logic [3:0] sel_tbl   [8] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8};
    logic [3:0] d42_lz    [4] = '{4'h2, 4'h4, 4'hF, 4'hF};
    logic [3:0] d42_nb    [4] = '{4'h2, 4'h4, 4'h0, 4'h0};
    logic [3:0] d00_lz    [4] = '{4'h0, 4'hF, 4'hF, 4'hF};
    logic [3:0] d00_nb    [4] = '{4'h0, 4'h0, 4'h0, 4'h0};

    always #5 clk = ~clk;

    digit_scan_counter_if #(.DIGITS(DIGITS)) ifa ();
    digit_scan_counter_if #(.DIGITS(DIGITS)) ifb ();

    assign ifb.en       = ifa.en;
    assign ifb.up       = ifa.up;
    assign ifb.clr      = ifa.clr;
    assign ifb.load     = ifa.load;
    assign ifb.load_val = ifa.load_val;

    digit_scan_counter #(.DIGITS(DIGITS), .TICK_DIV(1), .SCAN_DIV(2), .BLANK_LZ(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    digit_scan_counter #(.DIGITS(DIGITS), .TICK_DIV(1), .SCAN_DIV(2), .BLANK_LZ(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    function automatic logic [15:0] actual_of(kind_e k);
        case (k)
            K_VALUE:   return ifa.value;
            K_CARRY:   return {15'd0, ifa.carry};
            K_SEL:     return {12'd0, ifa.sel};
            K_DIGIT:   return {12'd0, ifa.digit};
            default:   return {12'd0, ifb.digit};
        endcase
    endfunction

    task automatic check(input exp_t e);
        logic [15:0] act;
        act = actual_of(e.kind);
        n_checks++;
        if (e.cyc != n) begin
            n_fail++;
            $display("FAIL %s: due cycle %0d, compared at cycle %0d", e.name, e.cyc, n);
        end else if (act !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", e.name, act, e.exp, n);
        end
    endtask

    // Monitor: compare every entry that falls due at this sample point.
    initial begin
        forever begin
            @(negedge clk);
            n++;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= n) begin
                    check(sb[i]);
                    sb.delete(i);
                end
            end
        end
    end

    // Queue an expectation for the sample after the next edge, plus d edges.
    task automatic expect_at(input kind_e k, input logic [15:0] v, input string nm, input int d = 0);
        exp_t e;
        e.cyc  = n + 2 + d;
        e.kind = k;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rst_n) m++;
        else       m = 0;
    endtask

    task automatic drive(input logic en, input logic up, input logic clr,
                         input logic load, input logic [15:0] lv);
        ifa.en       = en;
        ifa.up       = up;
        ifa.clr      = clr;
        ifa.load     = load;
        ifa.load_val = lv;
    endtask

    task automatic expect_scan(input logic [3:0] tlz [4], input logic [3:0] tnb [4], input string nm);
        int unsigned me;
        for (int d = 0; d < 8; d++) begin
            me = m + 1 + d;
            expect_at(K_DIGIT,   {12'd0, tlz[((me - 1) / 2) % 4]}, {nm, "_lz"}, d);
            expect_at(K_DIGIT_B, {12'd0, tnb[((me - 1) / 2) % 4]}, {nm, "_nb"}, d);
            expect_at(K_SEL,     {12'd0, sel_tbl[(me - 1) % 8]},   {nm, "_sel"}, d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        rst_n = 1'b0;
        step();
        expect_at(K_VALUE,   16'h0000, "rst_value");
        expect_at(K_SEL,     16'h0001, "rst_sel");
        expect_at(K_DIGIT,   16'h0000, "rst_digit");
        expect_at(K_CARRY,   16'h0000, "rst_carry");
        expect_at(K_VALUE,   16'h0000, "rst_value_hold", 1);
        step();
        step();

        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int d = 0; d < 9; d++)
            expect_at(K_SEL, {12'd0, sel_tbl[(m + d) % 8]}, "scan_after_rst", d);

        // Up-wrap through all nines.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h9998);
        expect_at(K_VALUE, 16'h9998, "up_load");
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        expect_at(K_VALUE, 16'h9999, "up_tick1");
        expect_at(K_CARRY, 16'h0000, "up_carry1");
        step();
        expect_at(K_VALUE, 16'h0000, "up_wrap");
        expect_at(K_CARRY, 16'h0001, "up_carry_wrap");
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        expect_at(K_CARRY, 16'h0000, "up_carry_drop");
        expect_at(K_VALUE, 16'h0000, "up_hold");
        step();

        // Down with ripple borrow, then wrap from zero.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h1000);
        expect_at(K_VALUE, 16'h1000, "dn_load");
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        expect_at(K_VALUE, 16'h0999, "dn_borrow");
        expect_at(K_CARRY, 16'h0000, "dn_carry0");
        step();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        expect_at(K_VALUE, 16'h0000, "dn_clr");
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        expect_at(K_VALUE, 16'h9999, "dn_wrap");
        expect_at(K_CARRY, 16'h0001, "dn_carry_wrap");
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        expect_at(K_CARRY, 16'h0000, "dn_carry_drop");
        step();

        // Priority: clr over load over tick, and a tick at 9999 is dropped.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
        expect_at(K_VALUE, 16'h0000, "pri_clr");
        expect_at(K_CARRY, 16'h0000, "pri_clr_carry");
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h1234);
        expect_at(K_VALUE, 16'h1234, "pri_load");
        expect_at(K_CARRY, 16'h0000, "pri_load_carry");
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h12AB);
        expect_at(K_VALUE, 16'h1200, "pri_sat");
        step();

        // Leading-zero blanking, with and without BLANK_LZ.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0042);
        expect_at(K_VALUE, 16'h0042, "blk_load");
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        expect_scan(d42_lz, d42_nb, "blk_0042");
        repeat (8) step();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        expect_scan(d00_lz, d00_nb, "blk_0000");
        repeat (8) step();

        // Reset in the middle of a scan at idx 2.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h5678);
        expect_at(K_VALUE, 16'h5678, "mid_load");
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        while (((m / 2) % 4) != 2) step();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        expect_at(K_VALUE, 16'h0000, "mid_rst_value");
        expect_at(K_SEL,   16'h0001, "mid_rst_sel");
        expect_at(K_DIGIT, 16'h0000, "mid_rst_digit");
        expect_at(K_CARRY, 16'h0000, "mid_rst_carry");
        step();
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int d = 0; d < 8; d++)
            expect_at(K_SEL, {12'd0, sel_tbl[(m + d) % 8]}, "mid_rescan", d);
        repeat (9) step();

        for (int t = 0; t < 20 && sb.size() > 0; t++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations never compared, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/digit_scan_counter.md
# digit_scan_counter

Four-decade BCD up/down counter with a built-in digit-scan multiplexer for a time-multiplexed 7-segment display. Each scan slot presents one 4-bit BCD nibble plus a one-hot digit select. The nibble feeds the existing BCD-to-segment decoder directly, which maps codes 4'hA–4'hF to all segments off. This block is the sequential stage immediately upstream of that decoder.

## Interface
- `DIGITS`, 4, number of decades and select lines (2–8)
- `TICK_DIV`, 50_000_000, clk cycles per count step (≥1)
- `SCAN_DIV`, 50_000, clk cycles per scan slot (≥1)
- `BLANK_LZ`, 1, 1 = blank leading zeros with code 4'hF
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `en` in 1: count enable; gates the prescaler
- `up` in 1: 1 = count up, 0 = count down; sampled on tick cycle
- `clr` in 1: synchronous clear of count and prescaler
- `load` in 1: synchronous load of `load_val`
- `load_val` in 4*DIGITS: BCD value; nibble 0 = least significant decade
- `digit` out 4: BCD nibble of current scan slot, or 4'hF when blanked; goes to the decoder `x`
- `sel` out DIGITS: one-hot active-high decade select
- `carry` out 1: one-cycle pulse on wrap, in either direction
- `value` out 4*DIGITS: live BCD count

## Operation
- Prescaler `pcnt` counts 0..TICK_DIV-1 while `en`=1, then returns to 0. `tick` is asserted in the cycle where `pcnt`==TICK_DIV-1 and `en`=1. When `en`=0, `pcnt` holds.
- Count update priority: `clr` > `load` > `tick`.
  - `clr`: `value`←0, `pcnt`←0.
  - `load`: each nibble ←`load_val` nibble. Any nibble >9 is loaded as 0. `pcnt` is unaffected.
  - `tick` with `up`=1: BCD increment with ripple carry across decades. Max value (all 9s) wraps to 0 and pulses `carry`.
  - `tick` with `up`=0: BCD decrement with ripple borrow. 0 wraps to all 9s and pulses `carry`.
- A `tick` coinciding with `clr` or `load` is discarded. `carry` stays 0 in that cycle.
- Scan: `scnt` counts 0..SCAN_DIV-1 continuously, independent of `en`, `clr` and `load`. At terminal count, index `idx` advances 0→1→…→DIGITS-1→0.
- `sel` = one-hot(`idx`).
- `digit` = nibble[`idx`] of `value`, with one exception: if `BLANK_LZ`=1, `idx`>0, and every nibble at positions ≥`idx` is 0, then `digit` = 4'hF. Decade 0 is never blanked.

## Timing
- Reset values (`rst_n`=0 at a rising edge): `value`=0, `pcnt`=0, `scnt`=0, `idx`=0, `sel`=1, `digit`=0, `carry`=0. Reset overrides every other input.
- `value` and `carry` update at the edge ending the tick, load or clr cycle. The latency is 1 clk.
- `digit` and `sel` are registered. They reflect `idx` and `value` with 1 clk of latency, so after a `load` the new nibble appears on `digit` 2 edges after `load` is sampled.
- `sel` changes only at scan-slot boundaries. It is always exactly one-hot with no all-zero gap.
- `up` toggling between ticks takes effect on the next tick.
- When TICK_DIV=1, a tick occurs on every `en` cycle. When SCAN_DIV=1, `idx` advances every clk.

## Structure
- Shared package holds: `DIGIT_W`=4, `DIGIT_BLANK`=4'hF, `BCD_MAX`=4'd9, and a function `bcd_sat` that returns 0 for any nibble >9.
- One sub-module, `bcd_decade`: a single 4-bit BCD digit with ports `inc`, `dec`, `ld`, `clr`, `ci`, `co` and registered `q`. It is instantiated DIGITS times with ripple `ci`/`co`.
- The prescaler, scan counter, blanking logic and output registers sit in the top level.

## Test plan
All scenarios use TICK_DIV=1 and SCAN_DIV=2 unless noted.
- **Reset:** hold `rst_n`=0 for 3 clk with `en`=1 → `value`=0, `sel`=4'b0001, `digit`=0, `carry`=0. After release, `sel` steps 0001→0010→0100→1000→0001, one step every 2 clk.
- **Up-wrap:** load 16'h9998, then `en`=1, `up`=1 for 2 clk → `value` goes 9999 then 0000. `carry`=1 only in the cycle after the second tick.
- **Down-borrow:** load 16'h1000, then 1 down tick → 0999. After that, clear and tick down once → 9999 with `carry` pulsed.
- **Blanking:** load 16'h0042 with `BLANK_LZ`=1 → `digit` cycles 2, 4, F, F. With `value`=0 → `digit` cycles 0, F, F, F. With `BLANK_LZ`=0 → 2, 4, 0, 0.
- **Priority:** assert `clr`, `load`=16'h1234 and a tick in the same cycle → `value`=0. Then `load` plus a tick in the same cycle → 1234, not 1235. Loading 16'h12AB → 1200.
- **Mid-operation reset:** with `value`=5678 and `idx`=2, pulse `rst_n`=0 for 1 clk → all outputs return to reset values at that edge. Scanning restarts at `sel`=0001.
